// File: rtl/alu_seq_ccr.sv
// alu_seq_ccr -- execute-stage ALU with registered result and condition-code
// register {N,C,Z}. Single-cycle ops update out/flag on the accepting edge; an
// optional unsigned multiply (op 4'b1101, MUL_EN=1) runs a WIDTH-cycle
// shift-add loop and holds off new ops through in_ready/busy.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   in_valid          operation presented this cycle
//   in_ready          ~busy; an op is accepted on in_valid & in_ready
//   aluControl        4-bit opcode
//   in1, in2          operands (in1 is also the unsigned shift amount)
//   flush             aborts a running multiply / suppresses the op accepted now
//   flag_restore_en   load CCR from flag_restore (beats any flag update)
//   flag_restore      {N,C,Z} restore value
//   out               registered result
//   out_valid         one-cycle pulse when out holds a new result
//   flag              registered CCR {N,C,Z}
//   busy              multiply in progress
module alu_seq_ccr #(
    parameter int WIDTH  = 16,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       aluControl,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             flush,
    input  logic             flag_restore_en,
    input  logic [2:0]       flag_restore,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic [2:0]       flag,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] W_AMT = WIDTH'(WIDTH);
    localparam logic [3:0] OP_MUL = 4'b1101;

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state_q;
    logic [CW-1:0]      cnt_q;
    logic [WIDTH-1:0]   out_q;
    logic               vld_q;
    logic [2:0]         flag_q;

    logic [2*WIDTH-1:0] acc_q, mcand_q, acc_d;
    logic [WIDTH-1:0]   mplier_q;

    logic [WIDTH-1:0]   res_d;
    logic [WIDTH:0]     ext_d;
    logic               wr_d, set_nz_d, set_c_d, c_d;
    logic               accept, mul_start;

    assign busy      = (state_q == RUN);
    assign in_ready  = ~busy;
    assign out       = out_q;
    assign out_valid = vld_q;
    assign flag      = flag_q;

    assign accept    = in_valid & in_ready;
    assign mul_start = MUL_EN && accept && !flush && (aluControl == OP_MUL);

    // One shift-add step; on the last RUN cycle this is the full product.
    assign acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);

    // Single-cycle result and flag-update selects.
    always_comb begin
        res_d    = '0;
        ext_d    = '0;
        wr_d     = 1'b0;
        set_nz_d = 1'b0;
        set_c_d  = 1'b0;
        c_d      = flag_q[1];
        case (aluControl)
            4'b0001: begin res_d = ~in2; wr_d = 1'b1; set_nz_d = 1'b1; end
            4'b0010, 4'b0100, 4'b0111, 4'b1000: begin
                case (aluControl)
                    4'b0010: ext_d = {1'b0, in1} + {1'b0, in2};
                    4'b0100: ext_d = {1'b0, in1} - {1'b0, in2};
                    4'b0111: ext_d = {1'b0, in2} + 1'b1;
                    default: ext_d = {1'b0, in2} - 1'b1;
                endcase
                // Bit WIDTH is carry for add/inc and borrow for sub/dec.
                res_d = ext_d[WIDTH-1:0];
                c_d   = ext_d[WIDTH];
                wr_d = 1'b1; set_nz_d = 1'b1; set_c_d = 1'b1;
            end
            4'b0011: begin res_d = in1; wr_d = 1'b1; end
            4'b0101: begin res_d = in1 & in2; wr_d = 1'b1; set_nz_d = 1'b1; end
            4'b0110: begin res_d = in1 | in2; wr_d = 1'b1; set_nz_d = 1'b1; end
            4'b1001: begin set_c_d = 1'b1; c_d = 1'b1; end
            4'b1010: begin set_c_d = 1'b1; c_d = 1'b0; end
            4'b1011, 4'b1100: begin
                wr_d = 1'b1; set_nz_d = 1'b1;
                if (in1 == '0) begin
                    res_d = in2;              // zero shift leaves C alone
                end else if (in1 > W_AMT) begin
                    res_d = '0; set_c_d = 1'b1; c_d = 1'b0;
                end else if (aluControl == 4'b1011) begin
                    // Extra top bit catches the last bit shifted out.
                    ext_d = {1'b0, in2} << in1;
                    res_d = ext_d[WIDTH-1:0]; set_c_d = 1'b1; c_d = ext_d[WIDTH];
                end else begin
                    ext_d = {in2, 1'b0} >> in1;
                    res_d = ext_d[WIDTH:1]; set_c_d = 1'b1; c_d = ext_d[0];
                end
            end
            default: ;
        endcase
    end

    // Control FSM, result and CCR registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            out_q   <= '0;
            vld_q   <= 1'b0;
            flag_q  <= 3'b000;
        end else begin
            vld_q <= 1'b0;
            case (state_q)
                RUN: begin
                    if (flush) begin
                        state_q <= IDLE;
                    end else if (cnt_q == LAST) begin
                        state_q <= IDLE;
                        out_q   <= acc_d[WIDTH-1:0];
                        vld_q   <= 1'b1;
                        flag_q  <= {acc_d[WIDTH-1], |acc_d[2*WIDTH-1:WIDTH],
                                    (acc_d[WIDTH-1:0] == '0)};
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    if (mul_start) begin
                        state_q <= RUN;
                        cnt_q   <= '0;
                    end else if (accept && !flush) begin
                        if (wr_d) begin
                            out_q <= res_d;
                            vld_q <= 1'b1;
                        end
                        if (set_nz_d) begin
                            flag_q[2] <= res_d[WIDTH-1];
                            flag_q[0] <= (res_d == '0);
                        end
                        if (set_c_d) flag_q[1] <= c_d;
                    end
                end
            endcase
            // Last assignment wins: restore overrides any update above.
            if (flag_restore_en) flag_q <= flag_restore;
        end
    end

    // Multiplier datapath: no reset needed, loaded on every multiply start.
    always_ff @(posedge clk) begin
        if (mul_start) begin
            acc_q    <= '0;
            mcand_q  <= {{WIDTH{1'b0}}, in1};
            mplier_q <= in2;
        end else if (state_q == RUN) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
        end
    end

endmodule
